// File: rtl/feature_wb_serializer.sv
// Write-back serializer: buffers feature vectors in a FWFT FIFO and streams each one
// to consecutive BRAM addresses inside a circular window, LANES features per word.
module feature_wb_serializer #(
  parameter int unsigned NUM_FEAT   = 16,
  parameter int unsigned FEAT_W     = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_DEPTH = 1024,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FEAT*FEAT_W-1:0]      in_vec,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic                            flush,
  input  logic                            bram_stall,
  output logic [ADDR_W-1:0]               bram_addr,
  output logic [LANES*FEAT_W-1:0]         bram_din,
  output logic                            bram_we,
  output logic                            vec_done,
  output logic                            addr_wrap,
  output logic [15:0]                     vec_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
  output logic                            busy
);

  localparam int unsigned BEATS  = NUM_FEAT / LANES;
  localparam int unsigned VEC_W  = NUM_FEAT * FEAT_W;
  localparam int unsigned WORD_W = LANES * FEAT_W;
  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [ADDR_W-1:0] AddrFirst = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] AddrLast  = ADDR_W'(BASE_ADDR + ADDR_DEPTH - 1);
  localparam logic [BW-1:0]     BeatLast  = BW'(BEATS - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  logic [VEC_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [0:0]        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [VEC_W-1:0]  shadow_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       vec_cnt_q;

  logic              push, pop, has_data;
  logic [BW-1:0]     word_idx, grp;
  logic [VEC_W-1:0]  src;
  logic [WORD_W-1:0] word;

  assign has_data = (cnt_q != '0);
  assign in_rdy   = (cnt_q < CW'(FIFO_DEPTH)) && !flush;
  assign push     = in_vld && in_rdy;
  assign bram_we  = !flush && !bram_stall && ((state_q == StEmit) || has_data);
  // In IDLE the write of word 0 doubles as the FIFO pop, so vectors chain with no bubble.
  assign pop      = bram_we && (state_q == StIdle);

  assign word_idx = (state_q == StIdle) ? '0 : beat_q;
  assign grp      = (MSB_FIRST != 0) ? (BeatLast - word_idx) : word_idx;
  assign src      = (state_q == StIdle) ? mem_q[rd_ptr_q] : shadow_q;

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (BW'(i) == grp) word = src[i*WORD_W +: WORD_W];
    end
  end

  assign bram_din  = bram_we ? word : '0;
  assign bram_addr = addr_q;
  assign vec_done  = bram_we && (word_idx == BeatLast);
  assign addr_wrap = bram_we && (addr_q == AddrLast);
  assign vec_cnt   = vec_cnt_q;
  assign fifo_cnt  = cnt_q;
  assign busy      = (state_q == StEmit) || has_data;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    if (bram_we) begin
      if (state_q == StIdle) begin
        if (BEATS > 1) begin
          state_d = StEmit;
          beat_d  = BW'(1);
        end
      end else if (beat_q == BeatLast) begin
        state_d = StIdle;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      beat_q    <= '0;
      shadow_q  <= '0;
      addr_q    <= AddrFirst;
      vec_cnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= StIdle;
      beat_q    <= '0;
      addr_q    <= AddrFirst;
      vec_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        shadow_q <= mem_q[rd_ptr_q];
      end
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      state_q <= state_d;
      beat_q  <= beat_d;
      if (bram_we) begin
        addr_q <= (addr_q == AddrLast) ? AddrFirst : addr_q + ADDR_W'(1);
        if (vec_done) vec_cnt_q <= vec_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_feature_wb_serializer.sv
// Randomized bench for feature_wb_serializer against a queue-based model of the write stream.
module tb_feature_wb_serializer;

  localparam int FD = 4, BASE = 16, DEPTH = 8, BEATS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] in_vec;
  logic         in_vld, flush, bram_stall, in_rdy, bram_we, vec_done, addr_wrap, busy;
  logic [9:0]   bram_addr;
  logic [31:0]  bram_din;
  logic [15:0]  vec_cnt;
  logic [2:0]   fifo_cnt;

  logic [127:0] in_vec2;
  logic         in_vld2, flush2, stall2, in_rdy2, bram_we2, vec_done2, addr_wrap2, busy2;
  logic [9:0]   bram_addr2;
  logic [31:0]  bram_din2;
  logic [15:0]  vec_cnt2;
  logic [2:0]   fifo_cnt2;

  feature_wb_serializer #(
    .NUM_FEAT(16), .FEAT_W(8), .LANES(4), .FIFO_DEPTH(4), .ADDR_W(10),
    .BASE_ADDR(16), .ADDR_DEPTH(8), .MSB_FIRST(1)
  ) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_vld(in_vld), .in_rdy(in_rdy),
    .flush(flush), .bram_stall(bram_stall), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_we(bram_we), .vec_done(vec_done), .addr_wrap(addr_wrap), .vec_cnt(vec_cnt),
    .fifo_cnt(fifo_cnt), .busy(busy)
  );

  feature_wb_serializer #(
    .NUM_FEAT(16), .FEAT_W(8), .LANES(4), .FIFO_DEPTH(4), .ADDR_W(10),
    .BASE_ADDR(16), .ADDR_DEPTH(8), .MSB_FIRST(0)
  ) dut_lsb (
    .clk(clk), .rst(rst), .in_vec(in_vec2), .in_vld(in_vld2), .in_rdy(in_rdy2),
    .flush(flush2), .bram_stall(stall2), .bram_addr(bram_addr2), .bram_din(bram_din2),
    .bram_we(bram_we2), .vec_done(vec_done2), .addr_wrap(addr_wrap2), .vec_cnt(vec_cnt2),
    .fifo_cnt(fifo_cnt2), .busy(busy2)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: queued vectors plus the remaining words of the vector being written.
  logic [127:0] m_fifo[$];
  logic [31:0]  m_words[$];
  int           m_off;
  logic [15:0]  m_vcnt;
  logic         e_we, e_rdy;
  logic [65:0]  e_bus;

  function automatic logic [31:0] group_word(logic [127:0] v, int k, bit msb);
    int g;
    g = msb ? (BEATS - 1 - k) : k;
    return v[g*32 +: 32];
  endfunction

  function automatic logic [65:0] obs_bus();
    return {in_rdy, bram_we, bram_addr, bram_din, vec_done, addr_wrap, vec_cnt, fifo_cnt, busy};
  endfunction

  function automatic logic [127:0] pattern_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i);
    return v;
  endfunction

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    m_fifo.delete();
    m_words.delete();
    m_off  = 0;
    m_vcnt = 16'd0;
  endtask

  task automatic model_eval();
    logic [31:0] w;
    bit          last;
    w    = 32'h0;
    last = 1'b0;
    e_we = !flush && !bram_stall && (m_words.size() > 0 || m_fifo.size() > 0);
    if (m_words.size() > 0) begin
      w    = m_words[0];
      last = (m_words.size() == 1);
    end else if (m_fifo.size() > 0) begin
      w    = group_word(m_fifo[0], 0, 1'b1);
      last = (BEATS == 1);
    end
    e_rdy = (m_fifo.size() < FD) && !flush;
    e_bus = {e_rdy, e_we, 10'(BASE + m_off), e_we ? w : 32'h0, e_we && last,
             e_we && (m_off == DEPTH - 1), m_vcnt, 3'(m_fifo.size()),
             (m_words.size() > 0 || m_fifo.size() > 0)};
  endtask

  task automatic model_advance();
    logic [127:0] v;
    if (flush) begin
      model_clear();
      return;
    end
    if (e_we) begin
      if (m_words.size() == 0) begin
        v = m_fifo.pop_front();
        for (int k = 0; k < BEATS; k++) m_words.push_back(group_word(v, k, 1'b1));
      end
      void'(m_words.pop_front());
      if (m_words.size() == 0) m_vcnt = m_vcnt + 16'd1;
      m_off = (m_off + 1) % DEPTH;
    end
    if (in_vld && e_rdy) m_fifo.push_back(in_vec);
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_vld = 0; flush = 0; bram_stall = 0; in_vec = '0;
    in_vld2 = 0; flush2 = 0; stall2 = 0; in_vec2 = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bram_we, bram_addr, bram_din, vec_done, addr_wrap, vec_cnt, fifo_cnt, busy} !==
        {1'b0, 10'h10, 32'h0, 1'b0, 1'b0, 16'h0, 3'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold: got we=%b addr=%h din=%h cnt=%0d fifo=%0d busy=%b",
               bram_we, bram_addr, bram_din, vec_cnt, fifo_cnt, busy);
    end
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    model_clear();
    sample();
    n_chk++;
    if (obs_bus() !== {1'b1, 1'b0, 10'h10, 32'h0, 1'b0, 1'b0, 16'h0, 3'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: got %h want in_rdy=1 addr=010 rest 0", obs_bus());
    end
    advance();
  endtask

  task automatic test_single();
    logic [31:0] exp_w[4];
    exp_w[0] = 32'h0F0E0D0C; exp_w[1] = 32'h0B0A0908;
    exp_w[2] = 32'h07060504; exp_w[3] = 32'h03020100;
    for (int c = 0; c < 7; c++) begin
      in_vld = (c == 0);
      in_vec = pattern_vec();
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL single_model c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      if (c >= 1 && c <= 4) begin
        n_chk++;
        if ({bram_we, bram_addr, bram_din, vec_done} !==
            {1'b1, 10'(16 + c - 1), exp_w[c-1], (c == 4)}) begin
          n_err++;
          $display("FAIL single_word c%0d: got we=%b addr=%h din=%h done=%b want addr=%h din=%h",
                   c, bram_we, bram_addr, bram_din, vec_done, 10'(16 + c - 1), exp_w[c-1]);
        end
      end
      if (c == 5) begin
        n_chk++;
        if (vec_cnt !== 16'd1 || bram_we !== 1'b0) begin
          n_err++;
          $display("FAIL single_count: got vec_cnt=%0d we=%b want 1 0", vec_cnt, bram_we);
        end
      end
      advance();
    end
  endtask

  task automatic test_order();
    logic [31:0] first_w, last_w;
    int          first_c;
    bit          got_done;
    first_w = '0; last_w = '0; first_c = -1; got_done = 0;
    in_vec2 = pattern_vec();
    in_vld2 = 1;
    @(posedge clk);
    #1;
    in_vld2 = 0;
    for (int c = 1; c <= 8 && !got_done; c++) begin
      @(negedge clk);
      if (bram_we2 && first_c < 0) begin
        first_c = c;
        first_w = bram_din2;
      end
      if (vec_done2) begin
        got_done = 1;
        last_w   = bram_din2;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (!got_done) begin
      n_err++;
      $display("FAIL order_timeout: got no vec_done within 8 cycles want done at cycle 4");
    end
    n_chk++;
    if (first_c != 1 || first_w !== 32'h03020100) begin
      n_err++;
      $display("FAIL order_first: got cycle %0d word %h want cycle 1 word 03020100",
               first_c, first_w);
    end
    n_chk++;
    if (last_w !== 32'h0F0E0D0C) begin
      n_err++;
      $display("FAIL order_last: got %h want 0f0e0d0c", last_w);
    end
  endtask

  task automatic test_burst();
    logic [127:0] vecs[6];
    int idx, nwr, first_c, last_c;
    bit saw_full;
    logic [31:0] wrap_mask;
    idx = 0; nwr = 0; first_c = -1; last_c = -1; saw_full = 0; wrap_mask = '0;
    for (int i = 0; i < 6; i++) vecs[i] = rand_vec();
    flush = 1;
    sample();
    n_chk++;
    if (obs_bus() !== e_bus) begin
      n_err++;
      $display("FAIL burst_flush: got %h want %h", obs_bus(), e_bus);
    end
    advance();
    flush = 0;
    for (int c = 0; c < 40; c++) begin
      in_vld = (idx < 6);
      in_vec = vecs[idx < 6 ? idx : 5];
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL burst_model c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      if (in_vld && !in_rdy) saw_full = 1;
      if (bram_we) begin
        nwr++;
        if (first_c < 0) first_c = c;
        last_c = c;
        if (addr_wrap && nwr < 32) wrap_mask[nwr] = 1'b1;
      end
      if (in_vld && e_rdy) idx++;
      advance();
    end
    in_vld = 0;
    n_chk++;
    if (!saw_full) begin
      n_err++;
      $display("FAIL burst_backpressure: got in_rdy never low want low once 4 buffered");
    end
    n_chk++;
    if (nwr != 24 || (last_c - first_c + 1) != 24) begin
      n_err++;
      $display("FAIL burst_stream: got %0d writes over %0d cycles want 24 over 24",
               nwr, last_c - first_c + 1);
    end
    n_chk++;
    if (wrap_mask !== 32'h0101_0100) begin
      n_err++;
      $display("FAIL burst_wrap: got mask %h want 01010100 (writes 8,16,24)", wrap_mask);
    end
  endtask

  task automatic test_stall();
    int done_c;
    logic [9:0] held;
    done_c = -1; held = '0;
    for (int c = 0; c < 12; c++) begin
      in_vld = (c == 0);
      in_vec = rand_vec();
      bram_stall = (c >= 3 && c < 6);
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL stall_model c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      if (c == 3) held = bram_addr;
      if (c >= 4 && c <= 6) begin
        n_chk++;
        if (bram_addr !== held || bram_we !== (c == 6)) begin
          n_err++;
          $display("FAIL stall_hold c%0d: got addr=%h we=%b want addr=%h we=%b",
                   c, bram_addr, bram_we, held, (c == 6));
        end
      end
      if (vec_done && done_c < 0) done_c = c;
      advance();
    end
    bram_stall = 0;
    in_vld = 0;
    n_chk++;
    if (done_c != 7) begin
      n_err++;
      $display("FAIL stall_latency: got done at cycle %0d want 7", done_c);
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 10; c++) begin
      in_vld = (c < 3) || (c == 4);
      in_vec = rand_vec();
      flush  = (c == 3);
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL flush_model c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      if (c == 3) begin
        n_chk++;
        if (bram_we !== 1'b0 || fifo_cnt !== 3'd2) begin
          n_err++;
          $display("FAIL flush_cycle: got we=%b fifo=%0d want 0 2", bram_we, fifo_cnt);
        end
      end
      if (c == 4) begin
        n_chk++;
        if ({fifo_cnt, bram_addr, vec_cnt, busy} !== {3'd0, 10'h10, 16'd0, 1'b0}) begin
          n_err++;
          $display("FAIL flush_after: got fifo=%0d addr=%h cnt=%0d busy=%b want 0 010 0 0",
                   fifo_cnt, bram_addr, vec_cnt, busy);
        end
      end
      if (c == 5) begin
        n_chk++;
        if (bram_we !== 1'b1 || bram_addr !== 10'h10) begin
          n_err++;
          $display("FAIL flush_restart: got we=%b addr=%h want 1 010", bram_we, bram_addr);
        end
      end
      advance();
    end
    in_vld = 0;
    flush  = 0;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 8; c++) begin
      in_vld = (c < 3);
      in_vec = rand_vec();
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL areset_model c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      if (c < 7) advance();
    end
    in_vld = 0;
    #2;
    rst = 1;
    #1;
    model_clear();
    n_chk++;
    if ({bram_we, bram_addr, bram_din, vec_done, addr_wrap, vec_cnt, fifo_cnt, busy} !==
        {1'b0, 10'h10, 32'h0, 1'b0, 1'b0, 16'h0, 3'h0, 1'b0}) begin
      n_err++;
      $display("FAIL areset_immediate: got we=%b addr=%h din=%h cnt=%0d fifo=%0d busy=%b",
               bram_we, bram_addr, bram_din, vec_cnt, fifo_cnt, busy);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (bram_we !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL areset_held c%0d: got we=%b busy=%b want 0 0", c, bram_we, busy);
      end
    end
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL areset_after c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_vld     = $urandom_range(0, 1) == 1;
      in_vec     = rand_vec();
      bram_stall = ($urandom % 4) == 0;
      flush      = ($urandom % 40) == 0;
      sample();
      n_chk++;
      if (obs_bus() !== e_bus) begin
        n_err++;
        $display("FAIL random_model c%0d: got %h want %h", c, obs_bus(), e_bus);
      end
      advance();
    end
    in_vld = 0; bram_stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_burst();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/feature_wb_serializer.md
# feature_wb_serializer

Parametrised write-back serializer for the aggregator's output path. Buffers complete feature vectors from the aggregation datapath in an internal FIFO, splits each vector into BRAM words of `LANES` features, and writes them to consecutive feature-BRAM addresses. It adds four things to the single-lane controller: multi-lane packing, selectable feature order, a circular address window, and BRAM stall, flush and per-vector completion status.

## Interface
Parameters:
- `NUM_FEAT`, 16: features per input vector.
- `FEAT_W`, 8: bits per feature.
- `LANES`, 4: features per BRAM word. Requires `NUM_FEAT % LANES == 0`. `BEATS = NUM_FEAT/LANES`.
- `FIFO_DEPTH`, 4: vector FIFO entries, power of two, ≥ 2.
- `ADDR_W`, 10: BRAM address width.
- `BASE_ADDR`, 0: first address of the write window.
- `ADDR_DEPTH`, 1024: window size in words. Requires `BASE_ADDR + ADDR_DEPTH ≤ 2^ADDR_W`.
- `MSB_FIRST`, 1: 1 writes the highest feature group first; 0 writes the lowest group first.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_vec`, in, `NUM_FEAT*FEAT_W`: feature vector. Feature i is at bits `[i*FEAT_W +: FEAT_W]`.
- `in_vld`, in, 1: `in_vec` valid.
- `in_rdy`, out, 1: vector accepted when `in_vld && in_rdy`.
- `flush`, in, 1: synchronous clear.
- `bram_stall`, in, 1: BRAM cannot accept a write this cycle.
- `bram_addr`, out, `ADDR_W`: write address.
- `bram_din`, out, `LANES*FEAT_W`: write data.
- `bram_we`, out, 1: write enable.
- `vec_done`, out, 1: pulses with the last word of each vector.
- `addr_wrap`, out, 1: pulses on the write to `BASE_ADDR+ADDR_DEPTH-1`.
- `vec_cnt`, out, 16: completed vectors, modulo 2^16.
- `fifo_cnt`, out, `$clog2(FIFO_DEPTH)+1`: FIFO occupancy.
- `busy`, out, 1: `state==EMIT || fifo_cnt != 0`.

## Operation
- FIFO is first-word-fall-through.
  - Push on `in_vld && in_rdy`.
  - `in_rdy = (fifo_cnt < FIFO_DEPTH) && !flush`. There is no push-through when full, even if a pop happens in the same cycle.
- Word k (k = 0..BEATS-1) of the current vector:
  - With `MSB_FIRST=0`, it is group g = k.
  - With `MSB_FIRST=1`, it is group g = BEATS-1-k.
  - Word contents are `vec[g*LANES*FEAT_W +: LANES*FEAT_W]`, with lane order preserved.
- State `IDLE`:
  - If `fifo_cnt != 0 && !bram_stall`: pop the FIFO, write word 0 from the FIFO head in the same cycle, and latch the vector into a shadow register.
  - Then go to `EMIT` with `beat = 1` if `BEATS > 1`; otherwise stay in `IDLE`.
- State `EMIT`:
  - Each cycle with `!bram_stall`, write word `beat` from the shadow register and increment `beat`.
  - On `beat == BEATS-1`, return to `IDLE`.
- `bram_stall` high in any state: no write, no pop; `beat`, address and state hold.
- Address register starts at `BASE_ADDR` and increments after each write. After `BASE_ADDR+ADDR_DEPTH-1` it wraps to `BASE_ADDR`, and `addr_wrap` pulses with that write.
- `vec_done` is asserted combinationally with the write of word BEATS-1. `vec_cnt` increments on that cycle.
- `flush` has highest priority:
  - FIFO is emptied, state goes to `IDLE`, `beat = 0`, address returns to `BASE_ADDR`, `vec_cnt = 0`.
  - A partially written vector is abandoned.
  - No write and no push occur in the flush cycle.
- `bram_din` is driven to 0 whenever `bram_we = 0`.

## Timing
- Reset values: `in_rdy` = 1 once `rst` is low, `bram_we` = 0, `bram_addr` = `BASE_ADDR`, `bram_din` = 0, `vec_done` = 0, `addr_wrap` = 0, `vec_cnt` = 0, `fifo_cnt` = 0, `busy` = 0, state = `IDLE`.
- `rst` asserted mid-vector clears everything asynchronously. No further writes occur for that vector.
- Latency: a vector pushed at cycle t into an empty, idle block has word 0 written at t+1. Its last word is written at t+BEATS, absent stalls.
- Throughput: one word per cycle. Back-to-back vectors continue with no bubble, because the `IDLE` pop cycle writes word 0.
- Sustained input rate is one vector per BEATS cycles; the FIFO absorbs bursts up to `FIFO_DEPTH`.
- `addr_wrap` and `vec_done` may assert in the same cycle.

## Test plan
Configuration: `NUM_FEAT=16`, `FEAT_W=8`, `LANES=4`, `FIFO_DEPTH=4`, `BASE_ADDR=0x10`, `ADDR_DEPTH=8`, `MSB_FIRST=1`.

- **Single vector.** Push `in_vec` with feature i = i, at cycle 0.
  - Required: writes at cycles 1–4 to addresses 0x10–0x13.
  - Data: 0x0F0E0D0C, 0x0B0A0908, 0x07060504, 0x03020100.
  - `vec_done` on cycle 4; `vec_cnt` = 1.
- **Feature order.** Same vector with `MSB_FIRST=0`.
  - Required: first word 0x03020100, last word 0x0F0E0D0C.
- **Burst and backpressure.** Push 6 vectors back-to-back.
  - Required: `in_rdy` drops after 4 are buffered (plus the pop timing).
  - 24 consecutive writes with no idle cycle.
  - Addresses wrap 0x17 → 0x10, with `addr_wrap` at writes 8, 16 and 24.
- **Stall.** Assert `bram_stall` for 3 cycles during beat 2.
  - Required: `bram_we` low for 3 cycles, address and data held.
  - Completion is delayed by exactly 3 cycles.
- **Flush mid-vector.** Pulse `flush` after beat 1 with 2 vectors queued.
  - Required: no write that cycle; `fifo_cnt` = 0, `bram_addr` = 0x10, `vec_cnt` = 0, `busy` = 0.
  - The next pushed vector writes starting at 0x10.
- **Async reset mid-vector.** Assert `rst` during beat 2.
  - Required: all outputs take their reset values immediately, with no further writes.
